// File: rtl/lutram_access_arbiter_pkg.sv
// lutram_access_arbiter_pkg: shared constants and FSM states for the LUTRAM arbiter
// (LUTRAM_ARB_INIT_CLEAR_EN enables the post-reset clear sweep)
package lutram_access_arbiter_pkg;
  localparam int BYTE_LEN_IN_BITS = 8;
  typedef enum logic {LUTRAM_ARB_STATE_INIT, LUTRAM_ARB_STATE_SERVE} arb_state_t;
endpackage

// File: rtl/lutram_access_arbiter_lutram.sv
// single_port_lutram: distributed RAM with async read and byte-masked sync write
module single_port_lutram
  import lutram_access_arbiter_pkg::*;
#(
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
  parameter int NUM_SET = 64,
  parameter int SET_PTR_WIDTH_IN_BITS = $clog2(NUM_SET),
  parameter int WRITE_MASK_LEN = SINGLE_ENTRY_SIZE_IN_BITS / BYTE_LEN_IN_BITS
) (
  input  logic                                 clk_in,
  input  logic                                 access_en,
  input  logic [WRITE_MASK_LEN-1:0]            write_en,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     addr,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] write_data,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_data
);
  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] mem [NUM_SET];
  assign read_data = mem[addr];
  always_ff @(posedge clk_in)
    if (access_en)
      for (int b = 0; b < WRITE_MASK_LEN; b++)
        if (write_en[b])
          mem[addr][b*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS] <= write_data[b*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS];
endmodule

// File: rtl/lutram_access_arbiter_rr.sv
// lutram_rr_arbiter: round-robin grant starting at an owned pointer that moves past each winner
module lutram_rr_arbiter #(
  parameter int NUM_REQUESTER = 4,
  parameter int REQ_PTR_WIDTH_IN_BITS = $clog2(NUM_REQUESTER)
) (
  input  logic                             clk_in,
  input  logic                             reset_in,
  input  logic [NUM_REQUESTER-1:0]         request,
  input  logic                             advance,
  output logic [NUM_REQUESTER-1:0]         grant,
  output logic [REQ_PTR_WIDTH_IN_BITS-1:0] winner
);
  localparam int PW = REQ_PTR_WIDTH_IN_BITS;
  logic [PW-1:0] pointer;
  int j;
  // scan farthest-first so the requester nearest the pointer overwrites last
  always_comb begin
    grant = '0;
    winner = '0;
    j = 0;
    for (int i = NUM_REQUESTER - 1; i >= 0; i--) begin
      j = (int'(pointer) + i) % NUM_REQUESTER;
      if (request[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        winner = PW'(j);
      end
    end
  end
  always_ff @(posedge clk_in or negedge reset_in)
    if (!reset_in) pointer <= '0;
    else if (advance) pointer <= (int'(winner) == NUM_REQUESTER - 1) ? '0 : winner + 1'b1;
endmodule

// File: rtl/lutram_access_arbiter.sv
// lutram_access_arbiter: round-robin sharing of one single_port_lutram between clients;
// define LUTRAM_ARB_INIT_CLEAR_EN to zero the table after reset before serving.
module lutram_access_arbiter
  import lutram_access_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTER = 4,
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
  parameter int NUM_SET = 64,
  parameter int SET_PTR_WIDTH_IN_BITS = $clog2(NUM_SET),
  parameter int WRITE_MASK_LEN = SINGLE_ENTRY_SIZE_IN_BITS / BYTE_LEN_IN_BITS,
  parameter int REQ_PTR_WIDTH_IN_BITS = $clog2(NUM_REQUESTER)
) (
  input  logic                                               clk_in,
  input  logic                                               reset_in,
  input  logic [NUM_REQUESTER-1:0]                           request_valid_in,
  output logic [NUM_REQUESTER-1:0]                           request_ready_out,
  input  logic [NUM_REQUESTER*WRITE_MASK_LEN-1:0]            request_write_en_in,
  input  logic [NUM_REQUESTER*SET_PTR_WIDTH_IN_BITS-1:0]     request_addr_in,
  input  logic [NUM_REQUESTER*SINGLE_ENTRY_SIZE_IN_BITS-1:0] request_data_in,
  output logic [NUM_REQUESTER-1:0]                           response_valid_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]               response_data_out,
  output logic                                               init_done_out
);
  localparam int W = SINGLE_ENTRY_SIZE_IN_BITS;
  localparam int AW = SET_PTR_WIDTH_IN_BITS;
  localparam int ML = WRITE_MASK_LEN;
  logic [NUM_REQUESTER-1:0] grant;
  logic [REQ_PTR_WIDTH_IN_BITS-1:0] winner;
  logic serve, transfer, access_en;
  logic [ML-1:0] sel_we, mem_we;
  logic [AW-1:0] sel_addr, mem_addr;
  logic [W-1:0] sel_data, mem_wd, mem_rd;
  lutram_rr_arbiter #(.NUM_REQUESTER(NUM_REQUESTER), .REQ_PTR_WIDTH_IN_BITS(REQ_PTR_WIDTH_IN_BITS)) u_rr (
    .clk_in(clk_in), .reset_in(reset_in), .request(request_valid_in & {NUM_REQUESTER{serve}}),
    .advance(transfer), .grant(grant), .winner(winner)
  );
  assign request_ready_out = grant;
  assign transfer = |grant;
  assign sel_we = request_write_en_in[int'(winner)*ML +: ML];
  assign sel_addr = request_addr_in[int'(winner)*AW +: AW];
  assign sel_data = request_data_in[int'(winner)*W +: W];
`ifdef LUTRAM_ARB_INIT_CLEAR_EN
  arb_state_t state_q, state_d;
  logic [AW-1:0] sweep_q;
  always_ff @(posedge clk_in or negedge reset_in)
    if (!reset_in) begin
      state_q <= LUTRAM_ARB_STATE_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= (state_q == LUTRAM_ARB_STATE_INIT) ? sweep_q + 1'b1 : sweep_q;
    end
  always_comb begin
    state_d = state_q;
    if (state_q == LUTRAM_ARB_STATE_INIT && sweep_q == AW'(NUM_SET - 1)) state_d = LUTRAM_ARB_STATE_SERVE;
  end
  assign serve = state_q == LUTRAM_ARB_STATE_SERVE;
  assign access_en = serve ? transfer : 1'b1;
  assign mem_we = serve ? sel_we : '1;
  assign mem_addr = serve ? sel_addr : sweep_q;
  assign mem_wd = serve ? sel_data : '0;
`else
  logic done_q;
  always_ff @(posedge clk_in or negedge reset_in)
    if (!reset_in) done_q <= 1'b0;
    else done_q <= 1'b1;
  assign serve = done_q;
  assign access_en = transfer;
  assign mem_we = sel_we;
  assign mem_addr = sel_addr;
  assign mem_wd = sel_data;
`endif
  assign init_done_out = serve;
  single_port_lutram #(.SINGLE_ENTRY_SIZE_IN_BITS(W), .NUM_SET(NUM_SET), .SET_PTR_WIDTH_IN_BITS(AW), .WRITE_MASK_LEN(ML)) u_ram (
    .clk_in(clk_in), .access_en(access_en), .write_en(mem_we), .addr(mem_addr),
    .write_data(mem_wd), .read_data(mem_rd)
  );
  // read data is the pre-edge async value, so writes return the old word
  always_ff @(posedge clk_in or negedge reset_in)
    if (!reset_in) begin
      response_valid_out <= '0;
      response_data_out <= '0;
    end else begin
      response_valid_out <= grant;
      if (transfer) response_data_out <= mem_rd;
    end
endmodule
